// File: rtl/disp_scheduler_if.sv
// rtl/disp_scheduler_if.sv - requester/display handshake bundle for disp_scheduler
interface disp_scheduler_if;
   logic        reqA;
   logic [15:0] dataA;
   logic        reqB;
   logic [15:0] dataB;
   logic        grantA;
   logic        grantB;
   logic [15:0] dispData;
   logic        scanTick;

   // requester side: drives requests and values, observes grants and display
   modport master (
      output reqA, dataA, reqB, dataB,
      input  grantA, grantB, dispData, scanTick
   );

   // scheduler side
   modport slave (
      input  reqA, dataA, reqB, dataB,
      output grantA, grantB, dispData, scanTick
   );
endinterface

// File: rtl/disp_scheduler.sv
// rtl/disp_scheduler.sv - two-requester display arbiter with scan prescaler; optional DISP_SCHED_IDLE_BLANK_EN blanks the display in IDLE
module disp_scheduler #(
   parameter int SCAN_DIV   = 50000,
   parameter int HOLD_TICKS = 1000
) (
   input logic             clk,
   input logic             rst,
   disp_scheduler_if.slave bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

   state_t        state_q, state_d;
   logic          grant_a_q, grant_b_q;
   logic [15:0]   disp_q, disp_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          last_b_q, last_b_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;

   // prescaler next value; the tick is registered one count early so it lines up with count == SCAN_DIV-1
   always_comb begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      tick_d  = (presc_q == PRESC_PRE);
   end

   // free-running prescaler and registered scan strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   // arbitration: round robin from IDLE, hand-over on release, preemption only after the hold period
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.reqA && bus.reqB) state_d = last_b_q ? GNT_A : GNT_B;
            else if (bus.reqA)        state_d = GNT_A;
            else if (bus.reqB)        state_d = GNT_B;
         end
         GNT_A: begin
            if (!bus.reqA)                             state_d = bus.reqB ? GNT_B : IDLE;
            else if (bus.reqB && (hold_q == HOLD_MAX)) state_d = GNT_B;
         end
         GNT_B: begin
            if (!bus.reqB)                             state_d = bus.reqA ? GNT_A : IDLE;
            else if (bus.reqA && (hold_q == HOLD_MAX)) state_d = GNT_A;
         end
         default: state_d = IDLE;
      endcase
   end

   // next display value, hold counter and round-robin memory derived from the next state
   always_comb begin
      disp_d   = disp_q;
      hold_d   = hold_q;
      last_b_d = last_b_q;
      case (state_d)
         GNT_A: begin
            disp_d   = bus.dataA;
            last_b_d = 1'b0;
         end
         GNT_B: begin
            disp_d   = bus.dataB;
            last_b_d = 1'b1;
         end
         default: begin
`ifdef DISP_SCHED_IDLE_BLANK_EN
            disp_d = 16'hFFFF;
`else
            disp_d = disp_q;
`endif
         end
      endcase
      if (state_d != state_q)
         hold_d = '0;
      else if ((state_q != IDLE) && tick_q && (hold_q != HOLD_MAX))
         hold_d = hold_q + HW'(1);
   end

   // FSM state with registered grant and display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_a_q <= 1'b0;
         grant_b_q <= 1'b0;
         disp_q    <= 16'hFFFF;
         hold_q    <= '0;
         last_b_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         grant_a_q <= (state_d == GNT_A);
         grant_b_q <= (state_d == GNT_B);
         disp_q    <= disp_d;
         hold_q    <= hold_d;
         last_b_q  <= last_b_d;
      end
   end

   assign bus.grantA   = grant_a_q;
   assign bus.grantB   = grant_b_q;
   assign bus.dispData = disp_q;
   assign bus.scanTick = tick_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// tb/tb_disp_scheduler.sv - directed self-checking bench for disp_scheduler (SCAN_DIV=4, HOLD_TICKS=2)
module tb_disp_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_fail  = 0;
   int   edges   = 0;

   disp_scheduler_if dif ();

   disp_scheduler #(.SCAN_DIV(4), .HOLD_TICKS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   // rising edges since reset release; scanTick is expected after edges n with n % 4 == 3
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] idle_val(input logic [15:0] last);
`ifdef DISP_SCHED_IDLE_BLANK_EN
      return 16'hFFFF;
`else
      return last;
`endif
   endfunction

   initial begin
      int exp_b;
      int n;
      bit seen;
      dif.reqA  = 1'b0;
      dif.reqB  = 1'b0;
      dif.dataA = 16'h0000;
      dif.dataB = 16'h0000;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_grantA", 16'(dif.grantA), 16'h0);
      check("rst_grantB", 16'(dif.grantB), 16'h0);
      check("rst_disp", dif.dispData, 16'hFFFF);
      check("rst_tick", 16'(dif.scanTick), 16'h0);
      rst = 1'b0;

      // idle scan: ticks in the 4th, 8th and 12th cycles after release
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("idle_tick_%0d", c), 16'(dif.scanTick), 16'((c % 4) == 3));
         check($sformatf("idle_grants_%0d", c), 16'({dif.grantA, dif.grantB}), 16'h0);
      end
      check("idle_disp", dif.dispData, 16'hFFFF);

      // single request, then data tracking
      dif.reqA  = 1'b1;
      dif.dataA = 16'h1234;
      @(negedge clk);
      check("a_grant", 16'(dif.grantA), 16'h1);
      check("a_nogrant_b", 16'(dif.grantB), 16'h0);
      check("a_disp", dif.dispData, 16'h1234);
      dif.dataA = 16'h5678;
      @(negedge clk);
      check("a_follow", dif.dispData, 16'h5678);
      dif.reqA = 1'b0;
      @(negedge clk);
      check("a_release", 16'(dif.grantA), 16'h0);
      check("a_idle_disp", dif.dispData, idle_val(16'h5678));

      // fresh reset, both request together: A first, then direct hand-over to B
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      dif.reqA  = 1'b1;
      dif.reqB  = 1'b1;
      dif.dataA = 16'hAAAA;
      dif.dataB = 16'hBBBB;
      @(negedge clk);
      check("rr_first", 16'({dif.grantA, dif.grantB}), 16'h2);
      check("rr_first_disp", dif.dispData, 16'hAAAA);
      dif.reqA = 1'b0;
      @(negedge clk);
      check("handover", 16'({dif.grantA, dif.grantB}), 16'h1);
      check("handover_disp", dif.dispData, 16'hBBBB);
      dif.reqB = 1'b0;
      @(negedge clk);
      check("b_release", 16'({dif.grantA, dif.grantB}), 16'h0);
      check("b_idle_disp", dif.dispData, idle_val(16'hBBBB));

      // hold period: B must wait until two scanTicks after A's grant
      dif.reqA  = 1'b1;
      dif.dataA = 16'h1111;
      @(negedge clk);
      check("hold_a_grant", 16'(dif.grantA), 16'h1);
      n = edges;
      while ((n % 4) != 3) n++;
      exp_b = n + 4 + 2;
      dif.reqB = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (edges < exp_b) begin
            check($sformatf("hold_wait_e%0d", edges), 16'({dif.grantA, dif.grantB}), 16'h2);
         end else begin
            check("hold_preempt", 16'({dif.grantA, dif.grantB}), 16'h1);
            check("hold_preempt_disp", dif.dispData, 16'hBBBB);
            break;
         end
      end

      // asynchronous reset while B is granted and scanTick is high
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (dif.scanTick) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("async_tick_seen", 16'(seen), 16'h1);
      check("async_pre_grantB", 16'(dif.grantB), 16'h1);
      #2 rst = 1'b1;
      #1;
      check("async_grantB", 16'(dif.grantB), 16'h0);
      check("async_disp", dif.dispData, 16'hFFFF);
      check("async_tick", 16'(dif.scanTick), 16'h0);
      @(negedge clk);
      dif.reqA = 1'b0;
      dif.reqB = 1'b0;
      rst = 1'b0;

      // idle display behaviour after a grant of 16'h0042
      dif.reqA  = 1'b1;
      dif.dataA = 16'h0042;
      @(negedge clk);
      check("d42_grant", 16'(dif.grantA), 16'h1);
      check("d42_disp", dif.dispData, 16'h0042);
      dif.reqA = 1'b0;
      @(negedge clk);
      check("d42_idle_grant", 16'({dif.grantA, dif.grantB}), 16'h0);
      check("d42_idle_disp", dif.dispData, idle_val(16'h0042));

      // round robin: A was granted last, so B wins a simultaneous request
      dif.reqA  = 1'b1;
      dif.reqB  = 1'b1;
      dif.dataB = 16'h9876;
      @(negedge clk);
      check("rr_second", 16'({dif.grantA, dif.grantB}), 16'h1);
      check("rr_second_disp", dif.dispData, 16'h9876);
      dif.reqA = 1'b0;
      dif.reqB = 1'b0;
      @(negedge clk);
      check("final_idle", 16'({dif.grantA, dif.grantB}), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per scanTick pulse; legal range >= 2.
REQ-002 Parameter HOLD_TICKS, default 1000: minimum scanTicks a grant is held before preemption; legal range >= 1.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 reqA  in  1  requester A wants the display; level, held high while it wants access.
REQ-006 dataA  in  16  requester A value, four BCD digits, [15:12] = leftmost digit.
REQ-007 reqB  in  1  requester B request; same rules as reqA.
REQ-008 dataB  in  16  requester B value, same format as dataA.
REQ-009 grantA  out  1  A owns the display.
REQ-010 grantB  out  1  B owns the display.
REQ-011 dispData  out  16  value driven to the 4-digit BCD scan decoder inData.
REQ-012 scanTick  out  1  one-clk pulse every SCAN_DIV cycles; digit-advance strobe for the scan decoder.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; scanTick SHALL be high only in the cycle where the count equals SCAN_DIV-1.
REQ-014 The FSM SHALL have exactly three states: IDLE, GNT_A, GNT_B; grantA is high only in GNT_A and grantB only in GNT_B.
REQ-015 grantA and grantB SHALL never be high in the same cycle.
REQ-016 In IDLE, when exactly one req is high, the FSM SHALL enter that requester's grant state on the next edge (1-cycle request-to-grant latency).
REQ-017 In IDLE with both reqs high, the FSM SHALL grant the requester not granted most recently (round robin); lastGrant is B after reset, so A wins first.
REQ-018 On grant entry, holdCnt SHALL clear to 0; it SHALL increment on each scanTick while granted and saturate at HOLD_TICKS.
REQ-019 In GNT_x with own req low and other req low, the FSM SHALL return to IDLE on the next edge.
REQ-020 In GNT_x with own req low and other req high, the FSM SHALL move directly to the other grant state, with no IDLE cycle.
REQ-021 In GNT_x with own req high, other req high and holdCnt == HOLD_TICKS, the FSM SHALL move directly to the other grant state.
REQ-022 In GNT_x with own req high and holdCnt < HOLD_TICKS, the FSM SHALL stay in GNT_x regardless of the other req.
REQ-023 dispData SHALL be registered and take the granted requester's data on every edge where the next state is GNT_A or GNT_B, so it updates on the same edge as the grant.
REQ-024 In IDLE, dispData behaviour SHALL be as set in REQ-029/REQ-030.
REQ-025 The prescaler SHALL free-run, independent of FSM state.

Reset
REQ-026 While rst is high: state = IDLE, grantA = grantB = 0, dispData = 16'hFFFF, scanTick = 0, prescaler = 0, holdCnt = 0, lastGrant = B.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately, asynchronously and without waiting for clk; the first scanTick SHALL occur SCAN_DIV cycles after rst deasserts.

Configuration
REQ-028 The macro DISP_SCHED_IDLE_BLANK_EN SHALL select the IDLE display behaviour.
REQ-029 With DISP_SCHED_IDLE_BLANK_EN defined, dispData SHALL load 16'hFFFF (all digits decode blank) on the edge that enters IDLE.
REQ-030 Without DISP_SCHED_IDLE_BLANK_EN, dispData SHALL hold the last granted value in IDLE.

Verification (SCAN_DIV=4, HOLD_TICKS=2)
REQ-031 Release reset and idle 12 clks -> scanTick pulses at cycles 4, 8 and 12, each 1 clk wide; grants stay 0 and dispData = 16'hFFFF.
REQ-032 reqA=1 with dataA=16'h1234 -> grantA=1 and dispData=16'h1234 one edge later; change dataA to 16'h5678 -> dispData follows on the next edge.
REQ-033 reqA and reqB rise together after reset -> A granted first; drop reqA -> grantB rises on the next edge with grantA falling on the same edge, and no overlap occurs.
REQ-034 A granted with reqA held and reqB raised -> B granted only after the 2nd scanTick following A's grant; the B grant never occurs earlier.
REQ-035 Assert rst mid-GNT_B -> grantB, dispData and scanTick take reset values before the next clk edge.
REQ-036 Drop all reqs from GNT_A holding 16'h0042 -> dispData = 16'hFFFF with the macro defined, and 16'h0042 without it.
